// File: rtl/tpu_pkg.sv
// Shared Mini TPU definitions: datapath widths, the NOP encoding and the
// byte-assembler state type used by the instruction front end.
// Ports: none (package).
package tpu_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int INSTR_WIDTH = 2 * DATA_WIDTH;

   localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 16'h0000;

   // LOW: waiting for the low byte. HIGH: low byte held, waiting for the high byte.
   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } asm_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: DEPTH x WIDTH storage with wrap-bit pointers and level.
// Ports: clk/rst_n, clear (sync flush), push/wdata, pop, rdata (head entry,
// raw storage), full, empty, level (entry count, $clog2(DEPTH)+1 bits).
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // One extra pointer bit distinguishes full from empty when indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // clear wins over both operations in the same cycle.
   assign do_push = push && !full  && !clear;
   assign do_pop  = pop  && !empty && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: entries are only visible while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction front end: assembles 16-bit instructions from a
// low-byte-first 8-bit stream, buffers them in instr_fifo and presents them
// with valid/ready; drives NOP whenever nothing is buffered.
// Ports: clk/rst_n, byte_in/byte_valid/byte_ready (input stream), flush,
// instruction/instr_valid/instr_ready (to control unit).
// Optional build macro FETCH_STATUS_EN adds fifo_level and sticky overflow.
module instr_fetch
   import tpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    byte_in,
   input  logic                     byte_valid,
   output logic                     byte_ready,
   input  logic                     flush,
   output logic [INSTR_WIDTH-1:0]   instruction,
   output logic                     instr_valid,
   input  logic                     instr_ready
`ifdef FETCH_STATUS_EN
   ,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
`endif
);

   asm_state_t               state;
   asm_state_t               state_nxt;
   logic [DATA_WIDTH-1:0]    half_reg;
   logic                     load_low;
   logic                     push;
   logic                     pop;
   logic                     byte_acc;
   logic                     full;
   logic                     empty;
   logic [INSTR_WIDTH-1:0]   head;
   logic [$clog2(DEPTH):0]   level;

   // A low byte never needs FIFO space; only the completing high byte does.
   // Depends on registered state only, so instr_ready never reaches byte_ready.
   assign byte_ready = (state == LOW) || !full;
   assign byte_acc   = byte_valid && byte_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOW;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_low  = 1'b0;
      push      = 1'b0;
      if (flush) begin
         state_nxt = LOW;
      end else if (byte_acc) begin
         case (state)
            LOW: begin
               load_low  = 1'b1;
               state_nxt = HIGH;
            end
            HIGH: begin
               push      = 1'b1;
               state_nxt = LOW;
            end
            default: state_nxt = LOW;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        half_reg <= '0;
      else if (load_low) half_reg <= byte_in;
   end

   assign pop = instr_valid && instr_ready;

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (push),
      .wdata ({byte_in, half_reg}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign instr_valid = !empty;
   assign instruction = empty ? INSTR_NOP : head;

`ifdef FETCH_STATUS_EN
   assign fifo_level = level;

   // Sticky: a byte was offered while the block could not take it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         overflow <= 1'b0;
      else if (flush)                     overflow <= 1'b0;
      else if (byte_valid && !byte_ready) overflow <= 1'b1;
   end
`else
   logic unused_level;
   assign unused_level = ^level;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by random traffic,
// all checked against a queue-based reference model every cycle.
// Ports: none (top-level bench).
module tb_instr_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        flush;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
`ifdef FETCH_STATUS_EN
   logic [2:0]  fifo_level;
   logic        overflow;
`endif

   always #5 clk = ~clk;

   instr_fetch #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .flush       (flush),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
`ifdef FETCH_STATUS_EN
      ,
      .fifo_level  (fifo_level),
      .overflow    (overflow)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int dut_pops = 0;

   // Reference model: a queue of assembled instructions plus "holding a low byte".
   logic [15:0] q[$];
   bit          m_high;
   logic [7:0]  m_half;
   bit          m_ovf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return !m_high || (q.size() < DEPTH);
   endfunction

   function automatic logic [15:0] m_head();
      return (q.size() != 0) ? q[0] : 16'h0000;
   endfunction

   task automatic model_reset();
      q.delete();
      m_high = 1'b0;
      m_half = 8'h00;
      m_ovf  = 1'b0;
   endtask

   task automatic check_outputs();
      check("byte_ready",  {31'b0, byte_ready},  {31'b0, m_ready()});
      check("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
      check("instruction", {16'b0, instruction}, {16'b0, m_head()});
`ifdef FETCH_STATUS_EN
      check("fifo_level",  {29'b0, fifo_level},  q.size());
      check("overflow",    {31'b0, overflow},    {31'b0, m_ovf});
`endif
   endtask

   task automatic model_update();
      bit acc;
      bit pp;
      acc = byte_valid && m_ready();
      pp  = instr_ready && (q.size() != 0);
      if (flush) begin
         q.delete();
         m_high = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         if (byte_valid && !m_ready()) m_ovf = 1'b1;
         if (pp) void'(q.pop_front());
         if (acc) begin
            if (!m_high) begin
               m_half = byte_in;
               m_high = 1'b1;
            end else begin
               q.push_back({byte_in, m_half});
               m_high = 1'b0;
            end
         end
      end
   endtask

   // One clock: inputs already driven; compare at negedge, advance model, pass edge.
   task automatic step();
      @(negedge clk);
      check_outputs();
      if (instr_valid && instr_ready && !flush) dut_pops++;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit bv, input logic [7:0] b, input bit ir, input bit fl);
      byte_valid  = bv;
      byte_in     = b;
      instr_ready = ir;
      flush       = fl;
      step();
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_byte_ready"},  {31'b0, byte_ready},  32'd1);
      check({pfx, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
      check({pfx, "_instruction"}, {16'b0, instruction}, 32'h0);
`ifdef FETCH_STATUS_EN
      check({pfx, "_fifo_level"},  {29'b0, fifo_level},  32'd0);
      check({pfx, "_overflow"},    {31'b0, overflow},    32'd0);
`endif
   endtask

   int pops_before;

   initial begin
      rst_n       = 1'b0;
      byte_in     = 8'h00;
      byte_valid  = 1'b0;
      flush       = 1'b0;
      instr_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      // Basic assembly, low byte first, then pop back to NOP.
      drive(1, 8'h34, 0, 0);
      drive(1, 8'h12, 0, 0);
      check("first_valid", {31'b0, instr_valid}, 32'd1);
      check("first_instr", {16'b0, instruction}, 32'h1234);
      drive(0, 8'h00, 1, 0);
      check("pop_nop",   {16'b0, instruction}, 32'h0);
      check("pop_valid", {31'b0, instr_valid}, 32'd0);

      // Fill to DEPTH with no consumer.
      for (int i = 0; i < 8; i++) drive(1, 8'(8'h10 + i), 0, 0);
      check("full_low_ready", {31'b0, byte_ready}, 32'd1);
      drive(1, 8'hC1, 0, 0);
      check("full_high_ready", {31'b0, byte_ready}, 32'd0);
      drive(1, 8'hC2, 0, 0);
      drive(1, 8'hC2, 0, 0);
`ifdef FETCH_STATUS_EN
      check("overflow_set", {31'b0, overflow}, 32'd1);
`endif
      // Pop while full: high byte still refused this cycle, taken the next.
      drive(1, 8'hC2, 1, 0);
      check("after_pop_ready", {31'b0, byte_ready}, 32'd1);
      drive(1, 8'hC2, 0, 0);
`ifdef FETCH_STATUS_EN
      check("refill_level", {29'b0, fifo_level}, 32'd4);
`endif
      check("refill_low_ready", {31'b0, byte_ready}, 32'd1);
      for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0);
      check("drained", {31'b0, instr_valid}, 32'd0);

      // Streaming with consumer always ready: pointers wrap, order preserved.
      pops_before = dut_pops;
      for (int k = 1; k <= 10; k++) begin
         drive(1, 8'(k), 1, 0);
         drive(1, 8'(k), 1, 0);
      end
      drive(0, 8'h00, 1, 0);
      drive(0, 8'h00, 1, 0);
      check("stream_pops", dut_pops - pops_before, 32'd10);

      // Flush with a half instruction held and a byte offered at the same time.
      drive(1, 8'h11, 0, 0);
      drive(1, 8'h22, 0, 0);
      drive(1, 8'hAA, 0, 0);
      drive(1, 8'hBB, 0, 1);
      check("flush_empty", {31'b0, instr_valid}, 32'd0);
      drive(1, 8'h78, 0, 0);
      drive(1, 8'h56, 0, 0);
      check("post_flush_instr", {16'b0, instruction}, 32'h5678);
      drive(0, 8'h00, 1, 0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 39) == 0);
      end

      // Asynchronous reset in HIGH with two entries buffered.
      drive(0, 8'h00, 0, 1);
      for (int i = 0; i < 5; i++) drive(1, 8'(8'hE0 + i), 0, 0);
      check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 8'hCD, 0, 0);
      drive(1, 8'hAB, 0, 0);
      check("post_rst_instr", {16'b0, instruction}, 32'hABCD);
      drive(0, 8'h00, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Byte-serial instruction front end of the Mini TPU, sitting directly upstream of the control unit. Assembles 16-bit instructions from an 8-bit input stream (low byte first), buffers them in a small FIFO, and presents them to the control unit with a valid/ready handshake. Whenever nothing is buffered, it drives NOP (16'h0000) so the control unit idles safely.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- INSTR_WIDTH, 16, instruction width; fixed at 2 × DATA_WIDTH
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- byte_in  input  8  instruction byte
- byte_valid  input  1  byte_in is valid this cycle
- byte_ready  output  1  block accepts byte_in this cycle
- flush  input  1  synchronous clear of FIFO and half-assembled instruction
- instruction  output  16  head-of-FIFO instruction; 16'h0000 when empty
- instr_valid  output  1  FIFO non-empty
- instr_ready  input  1  control unit consumes the head this cycle
- fifo_level  output  $clog2(DEPTH)+1  entry count (only with FETCH_STATUS_EN)
- overflow  output  1  sticky dropped-byte flag (only with FETCH_STATUS_EN)

## Operation
- Assembler FSM states: LOW (expecting low byte) and HIGH (low byte held in half_reg, expecting high byte). Reset and flush → LOW.
- Byte accept = byte_valid && byte_ready.
- LOW + accept: half_reg ← byte_in, state → HIGH.
- HIGH + accept: push {byte_in, half_reg} into the FIFO, state → LOW.
- byte_ready = (state == LOW) || !full. There is no combinational path from instr_ready to byte_ready. A low byte is always accepted.
- Pop = instr_valid && instr_ready. Pop with instr_valid low is ignored.
- Push and pop in the same cycle: both take effect and count is unchanged. Push cannot occur while full.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - full = pointer MSBs differ and the remaining bits are equal.
  - empty = pointers are equal.
- instruction = mem[rd_ptr] when !empty, else 16'h0000. The output is driven combinationally from registers only.
- flush has priority over push and pop in the same cycle. It resets the pointers and the FSM. half_reg content is don't-care.

## Timing
- Reset values:
  - byte_ready = 1
  - instr_valid = 0
  - instruction = 16'h0000
  - state = LOW
  - pointers = 0
  - fifo_level = 0
  - overflow = 0
- Latency: high byte accepted at edge N → instr_valid = 1 with the new instruction from just after edge N (empty-FIFO case). Minimum 2 accepted bytes per instruction.
- Pop at edge N → next entry (or NOP) visible just after edge N.
- Throughput: one instruction per two byte cycles in, one instruction per cycle out.
- Reset asserted mid-instruction: the half-assembled byte is discarded and the FSM returns to LOW asynchronously.

## Configuration
- FETCH_STATUS_EN defined:
  - adds fifo_level (current count) and overflow.
  - overflow sets when byte_valid && !byte_ready and is cleared only by reset or flush.
- FETCH_STATUS_EN undefined: both ports and their logic are absent. Core behaviour is identical.

## Structure
- Shared package tpu_pkg holds:
  - DATA_WIDTH = 8
  - INSTR_WIDTH = 16
  - INSTR_NOP = 16'h0000
  - the assembler state typedef (LOW/HIGH)
- Sub-module instr_fifo:
  - parameterised DEPTH/width storage, pointers, full/empty and level.
  - instr_fetch wraps it with the assembler FSM and the handshake.

## Test plan
- Reset, then bytes 0x34, 0x12 → instr_valid = 1, instruction = 16'h1234 the cycle after the second byte. Pop → instruction = 16'h0000, instr_valid = 0.
- Push 4 instructions with instr_ready = 0 → after the 4th, byte_ready = 1 in LOW. After a 9th byte (state HIGH), byte_ready = 0. Holding byte_valid sets overflow (status build).
- Full FIFO with instr_ready = 1 and a simultaneous high byte → that byte is not accepted in that cycle. It is accepted the next cycle with fifo_level = 4.
- Stream 10 instructions 0x0101..0x0A0A with instr_ready = 1 → output in order, pointers wrap, no loss, no duplicates.
- Low byte 0xAA, then flush = 1 together with byte_valid → FIFO empty, state LOW. Next pair 0x78, 0x56 gives 16'h5678.
- Assert rst_n low while in HIGH with 2 entries buffered → all outputs return to their reset values immediately (asynchronous), before the next clock edge.
